// File: rtl/seg_display_arbiter_if.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter_if
// Purpose : bundles the requester-side and display-side signals of the
//           seven-segment display arbiter into one connection.
// Signals :
//   req          N_REQ        level request per requester
//   req_num      16*N_REQ     value of requester i at [16*i+15:16*i]
//   grant        N_REQ        one-hot owner, all-zero when idle
//   owner_id     $clog2(N_REQ) index of current owner (0 when idle)
//   busy         1            an owner is granted
//   num_out      16           registered value for the display driver
//   switch_pulse 1            one-cycle pulse on every grant change
// Modports:
//   master : requester/display side (drives req, req_num)
//   slave  : arbiter side (drives grant, owner_id, busy, num_out, switch_pulse)
// -----------------------------------------------------------------------------
interface seg_display_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_num;
  logic [N_REQ-1:0]    grant;
  logic [ID_W-1:0]     owner_id;
  logic                busy;
  logic [15:0]         num_out;
  logic                switch_pulse;

  modport master (
    output req, req_num,
    input  grant, owner_id, busy, num_out, switch_pulse
  );

  modport slave (
    input  req, req_num,
    output grant, owner_id, busy, num_out, switch_pulse
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Purpose : shares one 4-digit seven-segment display between N_REQ requesters.
//           Round-robin ownership with a minimum dwell of HOLD_CYCLES so every
//           value stays readable; the owner's value is forwarded to num_out
//           every cycle (one cycle of lag).
// Parameters:
//   N_REQ        number of requesters, 2..8
//   HOLD_CYCLES  minimum owner dwell in clk cycles, >= 2
//   IDLE_VALUE   num_out value while nobody owns the display
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of seg_display_arbiter_if (req, req_num in;
//          grant, owner_id, busy, num_out, switch_pulse out)
// Optional feature:
//   SEG_ARB_PREEMPT_EN  when defined, requester 0 is urgent and takes the
//                       display from any other owner at the next edge,
//                       ignoring the dwell counter.
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
  parameter int          N_REQ       = 4,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_display_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SUM_W = ID_W + 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [SUM_W-1:0] N_SUM     = SUM_W'(N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_OPEN
  } state_t;

  state_t            r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [ID_W-1:0]   r_owner_id;
  logic              r_busy;
  logic [15:0]       r_num_out;
  logic              r_switch_pulse;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [ID_W-1:0]   r_rr_ptr;

  logic [15:0]       w_req_num [N_REQ];
  logic [N_REQ-1:0]  w_cand;
  logic [N_REQ-1:0]  w_rot;
  logic [ID_W-1:0]   w_rot_idx [N_REQ];
  logic [ID_W-1:0]   w_off;
  logic              w_found;
  logic [ID_W-1:0]   w_win;
  logic [ID_W-1:0]   w_win_next;
  logic              w_owner_req;
  logic              w_dwell_done;
  logic              w_take;
  logic              w_drop;
  logic [ID_W-1:0]   w_take_idx;
  logic [ID_W-1:0]   w_take_ptr;
  logic [N_REQ-1:0]  w_take_grant;

  // The current owner never competes against itself: in IDLE r_grant is zero,
  // and on release the owner's req is already low.
  assign w_cand = bus.req & ~r_grant;

  // Rotate the candidate vector so position 0 is the requester at rr_ptr.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [SUM_W-1:0] w_sum;
    assign w_sum          = {1'b0, r_rr_ptr} + SUM_W'(gi);
    assign w_rot_idx[gi]  = (w_sum >= N_SUM) ? ID_W'(w_sum - N_SUM) : ID_W'(w_sum);
    assign w_rot[gi]      = w_cand[w_rot_idx[gi]];
    assign w_req_num[gi]  = bus.req_num[16*gi +: 16];
  end

  // First set bit of the rotated vector = round-robin winner.
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
  end

  assign w_found    = |w_rot;
  assign w_win      = w_rot_idx[w_off];
  assign w_win_next = (w_win == LAST_ID) ? '0 : w_win + 1'b1;

  assign w_owner_req = |(bus.req & r_grant);

  // The last HOLD cycle already behaves like OPEN, so a waiting requester
  // takes over exactly HOLD_CYCLES cycles after the grant edge.
  assign w_dwell_done = (r_state == ST_OPEN) ||
                        ((r_state == ST_HOLD) && (r_hold_cnt == HOLD_LAST));

  always_comb begin
    w_take     = 1'b0;
    w_drop     = 1'b0;
    w_take_idx = w_win;
    w_take_ptr = w_win_next;
    if (r_state == ST_IDLE) begin
      w_take = w_found;
    end else if (!w_owner_req) begin
      // Release overrides the dwell.
      w_take = w_found;
      w_drop = !w_found;
    end else if (w_dwell_done) begin
      w_take = w_found;
    end
`ifdef SEG_ARB_PREEMPT_EN
    if ((r_state != ST_IDLE) && (r_owner_id != '0) && bus.req[0]) begin
      w_take     = 1'b1;
      w_drop     = 1'b0;
      w_take_idx = '0;
      w_take_ptr = ID_W'(1);
    end
`endif
  end

  assign w_take_grant = {{(N_REQ-1){1'b0}}, 1'b1} << w_take_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_owner_id     <= '0;
      r_busy         <= 1'b0;
      r_num_out      <= IDLE_VALUE;
      r_switch_pulse <= 1'b0;
      r_hold_cnt     <= '0;
      r_rr_ptr       <= '0;
    end else if (w_take) begin
      // Every take moves the grant to a different requester.
      r_state        <= ST_HOLD;
      r_grant        <= w_take_grant;
      r_owner_id     <= w_take_idx;
      r_busy         <= 1'b1;
      r_num_out      <= w_req_num[w_take_idx];
      r_switch_pulse <= 1'b1;
      r_hold_cnt     <= '0;
      r_rr_ptr       <= w_take_ptr;
    end else if (w_drop) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_owner_id     <= '0;
      r_busy         <= 1'b0;
      r_num_out      <= IDLE_VALUE;
      r_switch_pulse <= 1'b1;
      r_hold_cnt     <= '0;
    end else begin
      r_switch_pulse <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_num_out <= w_req_num[r_owner_id];
      end
      // Counter stops at HOLD_LAST, so it can never wrap.
      if (r_state == ST_HOLD) begin
        if (r_hold_cnt == HOLD_LAST) begin
          r_state <= ST_OPEN;
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.grant        = r_grant;
  assign bus.owner_id     = r_owner_id;
  assign bus.busy         = r_busy;
  assign bus.num_out      = r_num_out;
  assign bus.switch_pulse = r_switch_pulse;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
// Purpose : self-checking bench for seg_display_arbiter (N_REQ=4,
//           HOLD_CYCLES=8). Stimulus pushes expected grant transactions into a
//           scoreboard queue; a monitor pops one entry per switch_pulse and
//           compares grant, owner_id, busy, num_out and the dwell since the
//           previous switch. Reset values and live num_out tracking are
//           compared directly.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

  localparam int N_REQ = 4;
  localparam int HOLD  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg_display_arbiter_if #(.N_REQ(N_REQ)) bus ();

  seg_display_arbiter #(
    .N_REQ       (N_REQ),
    .HOLD_CYCLES (HOLD),
    .IDLE_VALUE  (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  grant;
    logic [1:0]  id;
    logic        busy;
    logic [15:0] num;
    int          dwell;   // cycles since previous switch, 0 = not checked
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  int   last_pulse = 0;
  int   txn        = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] id, input logic b,
                      input logic [15:0] n, input int d);
    exp_t e;
    e.grant = g; e.id = id; e.busy = b; e.num = n; e.dwell = d;
    sb_q.push_back(e);
  endtask

  task automatic set_num(input int i, input logic [15:0] v);
    bus.req_num[16*i +: 16] = v;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_grant"}, 32'(bus.grant), 32'h0);
    chk({name, "_owner"}, 32'(bus.owner_id), 32'h0);
    chk({name, "_busy"},  32'(bus.busy), 32'h0);
    chk({name, "_num"},   32'(bus.num_out), 32'h0000);
    chk({name, "_pulse"}, 32'(bus.switch_pulse), 32'h0);
  endtask

  // Monitor: one scoreboard transaction per switch_pulse.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && bus.switch_pulse) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_switch grant=%b required=no_switch", bus.grant);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("txn%0d_grant", txn), 32'(bus.grant), 32'(mon_e.grant));
        chk($sformatf("txn%0d_owner", txn), 32'(bus.owner_id), 32'(mon_e.id));
        chk($sformatf("txn%0d_busy", txn), 32'(bus.busy), 32'(mon_e.busy));
        chk($sformatf("txn%0d_num", txn), 32'(bus.num_out), 32'(mon_e.num));
        if (mon_e.dwell != 0)
          chk($sformatf("txn%0d_dwell", txn), 32'(cyc - last_pulse), 32'(mon_e.dwell));
        $display("txn %0d grant=%b owner=%0d busy=%0b num=%h dwell=%0d",
                 txn, bus.grant, bus.owner_id, bus.busy, bus.num_out, cyc - last_pulse);
        txn++;
      end
      last_pulse = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req     = '0;
    bus.req_num = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;

    // 1: single request from IDLE, one-cycle pulse, async reset.
    @(negedge clk);
    set_num(0, 16'h1234);
    bus.req = 4'b0001;
    push(4'b0001, 2'd0, 1'b1, 16'h1234, 0);
    drain("t1", 4);
    @(negedge clk);
    chk("t1_pulse_one_cycle", 32'(bus.switch_pulse), 32'h0);
    #2 rst_n = 1'b0;
    #1 check_reset("t1_async_rst");
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // 2: all requesting, round-robin with 8-cycle dwell.
    set_num(0, 16'hA000); set_num(1, 16'hA001);
    set_num(2, 16'hA002); set_num(3, 16'hA003);
    @(negedge clk);
    bus.req = 4'b1111;
    push(4'b0001, 2'd0, 1'b1, 16'hA000, 0);
`ifdef SEG_ARB_PREEMPT_EN
    push(4'b0010, 2'd1, 1'b1, 16'hA001, HOLD);
    push(4'b0001, 2'd0, 1'b1, 16'hA000, 1);
    push(4'b0010, 2'd1, 1'b1, 16'hA001, HOLD);
    push(4'b0001, 2'd0, 1'b1, 16'hA000, 1);
`else
    push(4'b0010, 2'd1, 1'b1, 16'hA001, HOLD);
    push(4'b0100, 2'd2, 1'b1, 16'hA002, HOLD);
    push(4'b1000, 2'd3, 1'b1, 16'hA003, HOLD);
    push(4'b0001, 2'd0, 1'b1, 16'hA000, HOLD);
`endif
    drain("t2", 100);
    push(4'b0000, 2'd0, 1'b0, 16'h0000, 0);
    bus.req = '0;
    drain("t2_idle", 4);

    // 3: owner 2 releases mid-HOLD, requester 1 wins via wrap from ptr 3;
    //    its dwell restarts from zero.
    @(negedge clk);
    bus.req = 4'b0100;
    push(4'b0100, 2'd2, 1'b1, 16'hA002, 0);
    drain("t3_own2", 4);
    repeat (2) @(negedge clk);
    bus.req = 4'b0010;
    push(4'b0010, 2'd1, 1'b1, 16'hA001, 0);
    @(negedge clk);
    bus.req = 4'b1010;
    push(4'b1000, 2'd3, 1'b1, 16'hA003, HOLD);
    drain("t3", 20);
    push(4'b0000, 2'd0, 1'b0, 16'h0000, 0);
    bus.req = '0;
    drain("t3_idle", 4);

    // 4: lone owner 1 with a counting value; num_out follows one cycle late.
    @(negedge clk);
    begin
      logic [15:0] cur;
      cur = 16'h0100;
      set_num(1, cur);
      bus.req = 4'b0010;
      push(4'b0010, 2'd1, 1'b1, 16'h0100, 0);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        chk($sformatf("t4_track%0d", i), 32'(bus.num_out), 32'(cur));
        cur = cur + 16'h0001;
        set_num(1, cur);
      end
    end
    chk("t4_pending", 32'(sb_q.size()), 32'h0);
    set_num(1, 16'hA001);
    push(4'b0000, 2'd0, 1'b0, 16'h0000, 0);
    bus.req = '0;
    drain("t4_idle", 4);

    // 5: owner 3 at hold_cnt=2 when requester 0 arrives.
    @(negedge clk);
    bus.req = 4'b1000;
    push(4'b1000, 2'd3, 1'b1, 16'hA003, 0);
`ifdef SEG_ARB_PREEMPT_EN
    push(4'b0001, 2'd0, 1'b1, 16'hA000, 3);
`else
    push(4'b0001, 2'd0, 1'b1, 16'hA000, HOLD);
`endif
    repeat (3) @(negedge clk);
    bus.req = 4'b1001;
    drain("t5", 20);
    push(4'b0000, 2'd0, 1'b0, 16'h0000, 0);
    bus.req = '0;
    drain("t5_idle", 4);

    // 6: reset while owner 1 is in OPEN; afterwards rr_ptr restarts at 0.
    @(negedge clk);
    bus.req = 4'b0010;
    push(4'b0010, 2'd1, 1'b1, 16'hA001, 0);
    drain("t6_own1", 4);
    repeat (12) @(negedge clk);
    bus.req = 4'b1010;
    #1 rst_n = 1'b0;
    #1 check_reset("t6_async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(4'b0010, 2'd1, 1'b1, 16'hA001, 0);
    @(negedge clk);
    chk("t6_grant_one_edge", 32'(bus.grant), 32'h2);
    drain("t6", 2);
    push(4'b0000, 2'd0, 1'b0, 16'h0000, 0);
    bus.req = '0;
    drain("t6_idle", 4);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
